// File: rtl/nn_accel_pkg.sv
// Shared constants and loader state encoding for the MNIST accelerator front end.
package nn_accel_pkg;

   localparam int unsigned ROW_BITS   = 7;
   localparam int unsigned NUM_BEATS  = 28;
   localparam int unsigned IMG_BITS   = ROW_BITS * NUM_BEATS;
   localparam int unsigned BEAT_CNT_W = 5;

   typedef enum logic {
      LOAD  = 1'b0,
      READY = 1'b1
   } loader_state_t;

endpackage

// File: rtl/image_row_loader.sv
// Assembles a binary image from consecutive row-beats and hands it downstream
// over a ready/ack handshake, holding the image stable until acknowledged.
module image_row_loader #(
   parameter  int unsigned ROW_BITS  = nn_accel_pkg::ROW_BITS,
   parameter  int unsigned NUM_BEATS = nn_accel_pkg::NUM_BEATS,
   localparam int unsigned IMG_BITS  = ROW_BITS * NUM_BEATS
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [ROW_BITS-1:0]                 data_in,
   input  logic                                data_valid,
   input  logic                                frame_start,
   output logic                                data_accept,
   output logic [IMG_BITS-1:0]                 image_data,
   output logic                                image_ready,
   input  logic                                image_ack,
   output logic [nn_accel_pkg::BEAT_CNT_W-1:0] beat_cnt,
   output logic                                overflow_err,
   input  logic                                err_clr
);

   import nn_accel_pkg::*;

   loader_state_t         state;
   logic                  store;
   logic                  last_beat;
   logic [BEAT_CNT_W-1:0] wr_slot;

   always_comb begin
      data_accept = (state == LOAD) ? 1'b1 : image_ack;
      store       = data_valid & data_accept;
      // An acked beat in READY and a resync beat both start a new image at slot 0.
      wr_slot     = ((state == READY) || frame_start) ? '0 : beat_cnt;
      last_beat   = (beat_cnt == BEAT_CNT_W'(NUM_BEATS - 1)) && !frame_start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         image_data   <= '0;
         image_ready  <= 1'b0;
         beat_cnt     <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (store) begin
            image_data[int'(wr_slot) * ROW_BITS +: ROW_BITS] <= data_in;
         end

         // A drop in the same cycle as a clear wins, so no drop goes unreported.
         if ((state == READY) && !image_ack && data_valid) begin
            overflow_err <= 1'b1;
         end else if (err_clr) begin
            overflow_err <= 1'b0;
         end

         case (state)
            LOAD: begin
               if (data_valid) begin
                  if (frame_start) begin
                     beat_cnt <= BEAT_CNT_W'(1);
                  end else if (last_beat) begin
                     beat_cnt    <= '0;
                     state       <= READY;
                     image_ready <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end else if (frame_start) begin
                  beat_cnt <= '0;
               end
            end
            READY: begin
               if (image_ack) begin
                  state       <= LOAD;
                  image_ready <= 1'b0;
                  beat_cnt    <= data_valid ? BEAT_CNT_W'(1) : '0;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: doc/image_row_loader.md
Name: image_row_loader

Overview:
- Input stage of the MNIST accelerator. Sits directly upstream of the inference/classification stage.
- Assembles a 14x14 binary image from 28 consecutive 7-bit row-beats on the dedicated inputs into a 196-bit image register.
- Presents the completed image with a ready/ack handshake, so the downstream stage reads a stable image while the next one is held off.

Parameters:
- ROW_BITS, 7: bits per input beat.
- NUM_BEATS, 28: beats per image.
- IMG_BITS, ROW_BITS*NUM_BEATS (196): derived, not overridable; width of image_data.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  ROW_BITS  current beat of pixel bits.
- data_valid  in  1  data_in is valid this cycle.
- frame_start  in  1  resynchronise; the current beat (if valid) is beat 0.
- data_accept  out  1  combinational; a valid beat this cycle is stored.
- image_data  out  IMG_BITS  assembled image; beat k occupies bits [k*ROW_BITS +: ROW_BITS].
- image_ready  out  1  image_data is complete and stable.
- image_ack  in  1  downstream has consumed the image; sampled only while image_ready=1.
- beat_cnt  out  5  number of beats stored in the current image (0..27).
- overflow_err  out  1  sticky; a beat was dropped while image_ready=1.
- err_clr  in  1  clears overflow_err.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=LOAD, image_data=0, image_ready=0, beat_cnt=0, overflow_err=0. Reset mid-image discards the partial image. Reset while READY drops image_ready on the next edge.
- State machine, state LOAD:
  - data_accept=1.
  - data_valid=1 and frame_start=0: write data_in to slot beat_cnt, then beat_cnt+1.
  - data_valid=1 and frame_start=1: write to slot 0, beat_cnt<=1. The partial image is discarded; old bits in slots >0 are left but are don't-care.
  - frame_start=1 and data_valid=0: beat_cnt<=0.
  - Valid beat written when beat_cnt==27: beat_cnt<=0, state<=READY.
- State machine, state READY:
  - image_ready=1, and image_data must not change.
  - data_accept=image_ack.
  - image_ack=1: state<=LOAD and image_ready deasserts next cycle. A valid beat in the same cycle is stored as beat 0 of the next image (beat_cnt<=1), giving zero bubble. frame_start has no extra effect here.
  - image_ack=0 with data_valid=1: beat dropped, overflow_err<=1, beat_cnt unchanged.
- Latency: last beat accepted on edge N; image_ready=1 and image_data complete from edge N. That is 28 cycles minimum from the first beat to ready.
- overflow_err: set has priority over err_clr in the same cycle. Otherwise err_clr=1 clears it.
- image_ack is ignored in LOAD.
- Gaps in data_valid are allowed. There is no timeout; a partial image is held indefinitely.

Decomposition:
- Shared package nn_accel_pkg holds:
  - constants ROW_BITS=7, NUM_BEATS=28, IMG_BITS=196, BEAT_CNT_W=5;
  - the loader state encoding (LOAD, READY), for reuse by the downstream stage and the benches.
- No sub-module. The beat counter and slot-write decode stay inline.

Test Plan:
- Reset, then 28 back-to-back valid beats with data_in=beat index (0..27): image_ready rises on the 28th edge. Slot k=k, beat_cnt=0, overflow_err=0.
- Beats with data_valid toggling 1/0 every cycle (alternate 7'h7F/7'h00): ready after 55 cycles. Slot contents alternate 7F/00. beat_cnt increments only on valid cycles.
- Hold image_ack=0 in READY and drive 3 valid beats: image_data unchanged, data_accept=0, overflow_err=1. err_clr then clears it. err_clr with a concurrent dropped beat keeps it at 1.
- Assert image_ack together with a valid beat 7'h55 in READY: image_ready=0 next cycle, slot0=7'h55, beat_cnt=1. A further 27 beats give ready again.
- After 10 beats, apply frame_start with a valid 7'h2A: beat_cnt=1, slot0=7'h2A. 27 more beats give image_ready. frame_start alone after 5 beats gives beat_cnt=0.
- Assert rst after 20 beats, and separately while READY: all outputs return to reset values on the next edge. A full new image loads correctly afterwards.
